// File: rtl/disparity_normalizer.sv
// Windowed disparity normalizer: accumulates disp*conf and conf over win_size samples,
// then divides with a serial restoring divider. Define DISP_NORM_ROUND_EN for round-half-up.
module disparity_normalizer #(
  parameter int disp_bits = 5,
  parameter int win_size  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8+disp_bits-1:0] disp_conf_in,
  input  logic [7:0]             conf_in,
  input  logic                   in_valid,
  output logic [disp_bits-1:0]   disp_out,
  output logic [7:0]             conf_avg_out,
  output logic                   zero_conf,
  output logic                   out_valid,
  output logic                   overrun
);

  localparam int LW = $clog2(win_size);
  localparam int NW = 8 + disp_bits + LW;
  localparam int DW = 8 + LW;
  localparam int RW = NW + 1;
  localparam int BW = $clog2(disp_bits + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r, state_next_s;

  logic [NW-1:0]        num_acc_r;
  logic [DW-1:0]        den_acc_r;
  logic [LW-1:0]        cnt_r;
  logic [NW-1:0]        num_sum_s;
  logic [DW-1:0]        den_sum_s;
  logic [RW-1:0]        dividend_s;
  logic                 last_s;
  logic                 load_s;
  logic                 drop_s;

  logic [RW-1:0]        rem_r;
  logic [DW-1:0]        den_r;
  logic [disp_bits-1:0] quot_r;
  logic [BW-1:0]        bit_r;
  logic                 sat_r;
  logic                 zero_r;
  logic [RW-1:0]        trial_s;
  logic                 ge_s;
  logic                 bit_last_s;
  logic [disp_bits-1:0] quot_next_s;

  // Window sums including the current sample, and window-completion decode
  always_comb begin
    num_sum_s = num_acc_r + NW'(disp_conf_in);
    den_sum_s = den_acc_r + DW'(conf_in);
`ifdef DISP_NORM_ROUND_EN
    dividend_s = RW'(num_sum_s) + RW'(den_sum_s >> 1);
`else
    dividend_s = RW'(num_sum_s);
`endif
    last_s = in_valid && (cnt_r == LW'(win_size - 1));
    load_s = last_s && (state_r == IDLE);
    drop_s = last_s && (state_r != IDLE);
  end

  // Restoring-division step for the current quotient bit
  always_comb begin
    trial_s     = RW'(den_r) << bit_r;
    ge_s        = (rem_r >= trial_s);
    bit_last_s  = (bit_r == {BW{1'b0}});
    if (ge_s) begin
      quot_next_s = quot_r | (disp_bits'(1'b1) << bit_r);
    end else begin
      quot_next_s = quot_r;
    end
  end

  // Accumulators and sample counter; a completing sample restarts the window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_acc_r <= {NW{1'b0}};
      den_acc_r <= {DW{1'b0}};
      cnt_r     <= {LW{1'b0}};
    end else if (in_valid) begin
      if (last_s) begin
        num_acc_r <= {NW{1'b0}};
        den_acc_r <= {DW{1'b0}};
        cnt_r     <= {LW{1'b0}};
      end else begin
        num_acc_r <= num_sum_s;
        den_acc_r <= den_sum_s;
        cnt_r     <= cnt_r + LW'(1'b1);
      end
    end
  end

  // Divider state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Divider next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_s) begin
          state_next_s = DIV;
        end else begin
          state_next_s = IDLE;
        end
      end
      DIV: begin
        if (bit_last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DIV;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Divider datapath, result registers and sticky overrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_r        <= {RW{1'b0}};
      den_r        <= {DW{1'b0}};
      quot_r       <= {disp_bits{1'b0}};
      bit_r        <= {BW{1'b0}};
      sat_r        <= 1'b0;
      zero_r       <= 1'b0;
      disp_out     <= {disp_bits{1'b0}};
      conf_avg_out <= 8'd0;
      zero_conf    <= 1'b0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load_s) begin
            rem_r  <= dividend_s;
            den_r  <= den_sum_s;
            quot_r <= {disp_bits{1'b0}};
            bit_r  <= BW'(disp_bits - 1);
            zero_r <= (den_sum_s == {DW{1'b0}});
            // Quotient overflows disp_bits exactly when dividend >= divisor * 2^disp_bits
            sat_r  <= (dividend_s >= (RW'(den_sum_s) << disp_bits));
          end
        end
        DIV: begin
          if (ge_s) begin
            rem_r <= rem_r - trial_s;
          end
          quot_r <= quot_next_s;
          if (bit_last_s) begin
            out_valid    <= 1'b1;
            zero_conf    <= zero_r;
            conf_avg_out <= den_r[DW-1:LW];
            if (zero_r) begin
              disp_out <= {disp_bits{1'b0}};
            end else if (sat_r) begin
              disp_out <= {disp_bits{1'b1}};
            end else begin
              disp_out <= quot_next_s;
            end
          end else begin
            bit_r <= bit_r - BW'(1'b1);
          end
        end
        default: begin
        end
      endcase
      if (drop_s) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_disparity_normalizer.sv
// Self-checking bench: per-cycle comparison against a window-level arithmetic model,
// plus literal expectations for the directed scenarios.
module tb_disparity_normalizer;

  localparam int D = 5;
  localparam int MAXQ = 31;

  logic clk = 1'b0;
  logic reset;
  logic [12:0] dci [2];
  logic [7:0]  ci  [2];
  logic        iv  [2];
  logic [4:0]  dout[2];
  logic [7:0]  cavg[2];
  logic        zc  [2];
  logic        vo  [2];
  logic        ov  [2];

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  int win_sz[2] = '{8, 4};
  int m_num[2], m_den[2], m_cnt[2], m_due[2], m_busy[2], m_ovr[2];
  int p_d[2], p_c[2], p_z[2];
  int h_d[2], h_c[2], h_z[2];
  int strobes[2];
  int last_valid_cyc[2];
  int last_sample_cyc[2];

  disparity_normalizer #(.disp_bits(5), .win_size(8)) u0 (
    .clk(clk), .reset(reset), .disp_conf_in(dci[0]), .conf_in(ci[0]), .in_valid(iv[0]),
    .disp_out(dout[0]), .conf_avg_out(cavg[0]), .zero_conf(zc[0]), .out_valid(vo[0]),
    .overrun(ov[0]));

  disparity_normalizer #(.disp_bits(5), .win_size(4)) u1 (
    .clk(clk), .reset(reset), .disp_conf_in(dci[1]), .conf_in(ci[1]), .in_valid(iv[1]),
    .disp_out(dout[1]), .conf_avg_out(cavg[1]), .zero_conf(zc[1]), .out_valid(vo[1]),
    .overrun(ov[1]));

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0d expected=%0d at edge %0d", name, i, act, exp, edge_n);
    end
  endtask

  task automatic model_clear(input int i);
    m_num[i] = 0; m_den[i] = 0; m_cnt[i] = 0;
    m_due[i] = -1; m_busy[i] = -1000; m_ovr[i] = -1;
    h_d[i] = 0; h_c[i] = 0; h_z[i] = 0;
  endtask

  // Window-level model: result of a window is plain integer division of its sums
  task automatic model_sample(input int i, input int d, input int c, input int m);
    int q;
    m_num[i] += d;
    m_den[i] += c;
    m_cnt[i]++;
    if (m_cnt[i] == win_sz[i]) begin
      if (m_busy[i] >= m) begin
        if (m_ovr[i] < 0) m_ovr[i] = m;
      end else begin
        if (m_den[i] == 0) begin
          p_d[i] = 0; p_c[i] = 0; p_z[i] = 1;
        end else begin
`ifdef DISP_NORM_ROUND_EN
          q = (m_num[i] + m_den[i] / 2) / m_den[i];
`else
          q = m_num[i] / m_den[i];
`endif
          p_d[i] = (q > MAXQ) ? MAXQ : q;
          p_c[i] = m_den[i] / win_sz[i];
          p_z[i] = 0;
        end
        m_due[i] = m + D;
        m_busy[i] = m + D + 1;
      end
      m_num[i] = 0; m_den[i] = 0; m_cnt[i] = 0;
    end
  endtask

  // Compare process: outputs reflect the last rising edge; inputs feed the next one
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        model_clear(i);
        chk("rst_out_valid", i, vo[i], 0);
        chk("rst_disp_out", i, dout[i], 0);
        chk("rst_conf_avg", i, cavg[i], 0);
        chk("rst_zero_conf", i, zc[i], 0);
        chk("rst_overrun", i, ov[i], 0);
      end else begin
        if (m_due[i] == edge_n) begin
          h_d[i] = p_d[i]; h_c[i] = p_c[i]; h_z[i] = p_z[i];
          m_due[i] = -1;
          chk("out_valid", i, vo[i], 1);
        end else begin
          chk("out_valid", i, vo[i], 0);
        end
        chk("disp_out", i, dout[i], h_d[i]);
        chk("conf_avg_out", i, cavg[i], h_c[i]);
        chk("zero_conf", i, zc[i], h_z[i]);
        chk("overrun", i, ov[i], (m_ovr[i] >= 0 && edge_n >= m_ovr[i]) ? 1 : 0);
        if (vo[i]) begin
          strobes[i]++;
          last_valid_cyc[i] = edge_n;
        end
        if (iv[i]) model_sample(i, dci[i], ci[i], edge_n + 1);
      end
    end
  end

  task automatic send(input int i, input int d, input int c);
    @(posedge clk); #1;
    iv[1-i] = 1'b0;
    dci[i] = 13'(d); ci[i] = 8'(c); iv[i] = 1'b1;
    last_sample_cyc[i] = edge_n;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      iv[0] = 1'b0; iv[1] = 1'b0;
    end
  endtask

  initial begin
    int s0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dci[i] = 13'd0; ci[i] = 8'd0; iv[i] = 1'b0;
      strobes[i] = 0; last_valid_cyc[i] = 0; last_sample_cyc[i] = 0;
      model_clear(i);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // Constant (200,20) window
    for (int k = 0; k < 8; k++) send(0, 200, 20);
    idle(10);
    chk("lit_req028_disp", 0, dout[0], 10);
    chk("lit_req028_avg", 0, cavg[0], 20);
    chk("lit_req028_zero", 0, zc[0], 0);
    chk("lit_req028_latency", 0, last_valid_cyc[0] - last_sample_cyc[0], 6);
    chk("lit_req028_strobes", 0, strobes[0], 1);

    // Alternating (30,10)/(40,10): 280/80
    for (int k = 0; k < 8; k++) send(0, (k % 2 == 0) ? 30 : 40, 10);
    idle(10);
`ifdef DISP_NORM_ROUND_EN
    chk("lit_req029_disp", 0, dout[0], 4);
`else
    chk("lit_req029_disp", 0, dout[0], 3);
`endif
    chk("lit_req029_avg", 0, cavg[0], 10);

    // Zero confidence window
    for (int k = 0; k < 8; k++) send(0, 0, 0);
    idle(10);
    chk("lit_req030_disp", 0, dout[0], 0);
    chk("lit_req030_avg", 0, cavg[0], 0);
    chk("lit_req030_zero", 0, zc[0], 1);

    // Gapped input, one on three off
    for (int k = 0; k < 8; k++) begin
      send(0, 200, 20);
      idle(3);
    end
    idle(8);
    chk("lit_req033_disp", 0, dout[0], 10);
    chk("lit_req033_avg", 0, cavg[0], 20);
    chk("lit_req033_latency", 0, last_valid_cyc[0] - last_sample_cyc[0], 6);
    chk("lit_req033_strobes", 0, strobes[0], 4);

    // Saturation: 65528/8 = 8191 clamps to 31
    for (int k = 0; k < 8; k++) send(0, 8191, 1);
    idle(10);
    chk("lit_sat_disp", 0, dout[0], 31);
    chk("lit_sat_avg", 0, cavg[0], 1);

    // Reset during DIV discards the window
    s0 = strobes[0];
    for (int k = 0; k < 8; k++) send(0, 200, 20);
    idle(2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(10);
    chk("lit_req032_no_strobe", 0, strobes[0], s0);
    chk("lit_req032_disp0", 0, dout[0], 0);
    chk("lit_req032_avg0", 0, cavg[0], 0);
    for (int k = 0; k < 8; k++) send(0, 62, 2);
    idle(10);
    chk("lit_req032_disp", 0, dout[0], 31);
    chk("lit_req032_avg", 0, cavg[0], 2);
    chk("lit_req024_no_overrun", 0, ov[0], 0);

    // win_size=4, three back-to-back windows: middle one dropped
    for (int k = 0; k < 4; k++) send(1, 100, 10);
    for (int k = 0; k < 4; k++) send(1, 50, 5);
    for (int k = 0; k < 4; k++) send(1, 90, 3);
    idle(12);
    chk("lit_req031_strobes", 1, strobes[1], 2);
    chk("lit_req031_overrun", 1, ov[1], 1);
    chk("lit_req031_disp", 1, dout[1], 30);
    chk("lit_req031_avg", 1, cavg[1], 3);

    for (int i = 0; i < 2; i++) chk("no_pending_result", i, m_due[i], -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
